// File: rtl/kb_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key code type,
// idle row pattern, default timing, and row-pattern decode helpers.
package kb_scan_pkg;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } kb_state_t;

  typedef logic [3:0] key_code_t;

  localparam logic [3:0] ROWS_IDLE        = 4'hF;
  localparam int         SETTLE_CYC_DEF   = 4;
  localparam int         DEBOUNCE_CYC_DEF = 16;

  // True when exactly one row line is pulled low.
  function automatic logic single_low(input logic [3:0] r);
    logic [2:0] zeros;
    zeros = 3'd0;
    for (int i = 0; i < 4; i++) begin
      zeros = zeros + {2'b00, ~r[i]};
    end
    return (zeros == 3'd1);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/kb_row_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad rows; resets to the
// idle (all-high) pattern so no phantom press is seen out of reset.
module kb_row_sync
  import kb_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] rs
);

  logic [3:0] meta_reg;
  logic [3:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= ROWS_IDLE;
      sync_reg <= ROWS_IDLE;
    end else begin
      meta_reg <= row;
      sync_reg <= meta_reg;
    end
  end

  assign rs = sync_reg;

endmodule

// File: rtl/kb_4x4_scanner.sv
// 4x4 matrix keypad scanner: column drive, debounced press/release detection and a
// valid/ready key output. Define KB_SCAN_VALUE_EN to enable the nibble-shifted key history on value.
module kb_4x4_scanner
  import kb_scan_pkg::*;
#(
  parameter int SETTLE_CYC   = SETTLE_CYC_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  clm,
  input  logic [3:0]  row,
  output logic [3:0]  key_code,
  output logic        key_vld,
  input  logic        key_rdy,
  output logic        key_ovf,
  output logic [31:0] value
);

  localparam int SW = $clog2(SETTLE_CYC);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYC - 1);

  logic [3:0] rs;

  kb_row_sync u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .row   (row),
    .rs    (rs)
  );

  kb_state_t     state_reg,   state_next;
  logic [1:0]    col_reg,     col_next;
  logic [SW-1:0] settle_reg,  settle_next;
  logic [DW-1:0] cnt_reg,     cnt_next;
  logic [3:0]    pattern_reg, pattern_next;
  logic [1:0]    row_idx_reg, row_idx_next;
  logic          confirm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= SCAN;
      col_reg     <= 2'd0;
      settle_reg  <= '0;
      cnt_reg     <= '0;
      pattern_reg <= ROWS_IDLE;
      row_idx_reg <= 2'd0;
    end else begin
      state_reg   <= state_next;
      col_reg     <= col_next;
      settle_reg  <= settle_next;
      cnt_reg     <= cnt_next;
      pattern_reg <= pattern_next;
      row_idx_reg <= row_idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    col_next     = col_reg;
    settle_next  = settle_reg;
    cnt_next     = cnt_reg;
    pattern_next = pattern_reg;
    row_idx_next = row_idx_reg;
    confirm      = 1'b0;
    case (state_reg)
      SCAN: begin
        if (settle_reg == SETTLE_LAST) begin
          settle_next = '0;
          if (rs != ROWS_IDLE && single_low(rs)) begin
            pattern_next = rs;
            row_idx_next = low_index(rs);
            cnt_next     = '0;
            state_next   = CONFIRM;
          end else begin
            // Idle rows or a multi-key ghost pattern both just move on.
            col_next = col_reg + 2'd1;
          end
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end
      CONFIRM: begin
        if (rs == pattern_reg) begin
          if (cnt_reg == DEB_LAST) begin
            confirm    = 1'b1;
            state_next = HELD;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else begin
          state_next  = SCAN;
          settle_next = '0;
        end
      end
      HELD: begin
        if (rs == ROWS_IDLE) begin
          state_next = RELEASE;
          cnt_next   = '0;
        end
      end
      RELEASE: begin
        if (rs == ROWS_IDLE) begin
          if (cnt_reg == DEB_LAST) begin
            state_next  = SCAN;
            col_next    = col_reg + 2'd1;
            settle_next = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else begin
          state_next = HELD;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  assign clm = ~(4'b0001 << col_reg);

  key_code_t key_code_reg;
  logic      key_vld_reg;
  logic      key_ovf_reg;
  logic      load;

  // A confirmed key may load in the same cycle the consumer drains the previous one.
  assign load = confirm && (!key_vld_reg || key_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code_reg <= '0;
      key_vld_reg  <= 1'b0;
      key_ovf_reg  <= 1'b0;
    end else begin
      key_ovf_reg <= confirm && !load;
      if (load) begin
        key_code_reg <= {col_reg, row_idx_reg};
        key_vld_reg  <= 1'b1;
      end else if (key_vld_reg && key_rdy) begin
        key_vld_reg <= 1'b0;
      end
    end
  end

  assign key_code = key_code_reg;
  assign key_vld  = key_vld_reg;
  assign key_ovf  = key_ovf_reg;

`ifdef KB_SCAN_VALUE_EN
  logic [31:0] value_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= {value_reg[27:0], col_reg, row_idx_reg};
    end
  end

  assign value = value_reg;
`else
  assign value = 32'h0;
`endif

endmodule

// File: tb/tb_kb_4x4_scanner.sv
// Self-checking bench for kb_4x4_scanner: keypad model driven from clm, scoreboard of
// expected key codes popped on each accepted key.
module tb_kb_4x4_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_rdy = 1'b1;
  logic [3:0]  clm;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_vld;
  logic        key_ovf;
  logic [31:0] value;

  logic [15:0] pressed = '0;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_code;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          ovf_seen = 0;

  always #5 clk = ~clk;

  kb_4x4_scanner dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clm      (clm),
    .row      (row),
    .key_code (key_code),
    .key_vld  (key_vld),
    .key_rdy  (key_rdy),
    .key_ovf  (key_ovf),
    .value    (value)
  );

  // Keypad model: key k = {col,row}; a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[c*4 + r] && !clm[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard consumer: every accepted key must match the next expected code.
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_ovf) ovf_seen++;
      if (key_vld && key_rdy) begin
        if (exp_q.size() == 0) begin
          n_assert++;
          assert (1'b0) else begin
            n_fail++;
            $error("FAIL unexpected_key: observed code %0h expected no key", key_code);
          end
        end else begin
          exp_code = exp_q.pop_front();
          $display("key accepted: code=%0h expected=%0h t=%0t", key_code, exp_code, $time);
          check("key_code", {28'd0, key_code}, {28'd0, exp_code});
        end
      end
    end
  end

  initial begin
    logic [3:0] prev_clm;
    logic [3:0] rot_clm;
    int         trans;
    int         k;

    // Reset state
    cycles(3);
    check("rst_clm", {28'd0, clm}, 32'he);
    check("rst_key_vld", {31'd0, key_vld}, 32'd0);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    check("rst_key_ovf", {31'd0, key_ovf}, 32'd0);
    check("rst_value", value, 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // 1: key 6 held 100 cycles -> single key, clm parked on column 1
    exp_q.push_back(4'd6);
    pressed[6] = 1'b1;
    wait_drain("t1_latency", 40);
    cycles(20);
    check("t1_clm_held", {28'd0, clm}, 32'hd);
    cycles(40);
    pressed = '0;
    cycles(60);

    // 2: 5-cycle glitch on key 9 -> nothing, scan keeps rotating
    pressed[9] = 1'b1;
    cycles(5);
    pressed = '0;
    prev_clm = clm;
    trans = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (clm != prev_clm) begin
        rot_clm = {prev_clm[2:0], prev_clm[3]};
        check("t2_clm_order", {28'd0, clm}, {28'd0, rot_clm});
        trans++;
        prev_clm = clm;
      end
    end
    check("t2_clm_cycling", {31'd0, trans >= 6}, 32'd1);
    check("t2_no_key", {31'd0, key_vld}, 32'd0);

    // 3: consumer stalled -> key 3 held, key 12 dropped with one overflow pulse
    key_rdy = 1'b0;
    ovf_seen = 0;
    exp_q.push_back(4'd3);
    pressed[3] = 1'b1;
    cycles(60);
    pressed = '0;
    cycles(40);
    pressed[12] = 1'b1;
    cycles(60);
    pressed = '0;
    cycles(40);
    check("t3_vld_held", {31'd0, key_vld}, 32'd1);
    check("t3_code_held", {28'd0, key_code}, 32'd3);
    check("t3_ovf_count", 32'(ovf_seen), 32'd1);
    key_rdy = 1'b1;
    wait_drain("t3_drain", 5);
    cycles(1);
    check("t3_vld_clear", {31'd0, key_vld}, 32'd0);

    // 4: keys 0 and 1 together on one column -> ghost, ignored
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    cycles(100);
    check("t4_no_key", {31'd0, key_vld}, 32'd0);
    pressed = '0;
    cycles(20);

    // 5: fresh history, press 1,2,3,4
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(4'(i));
      pressed[i] = 1'b1;
      wait_drain("t5_key", 45);
      cycles(5);
      pressed = '0;
      cycles(40);
    end
`ifdef KB_SCAN_VALUE_EN
    check("t5_value", value, 32'h0000_1234);
`else
    check("t5_value", value, 32'h0);
`endif

    // 6: reset while key 5 is held -> immediate clear, nothing on release
    key_rdy = 1'b0;
    pressed[5] = 1'b1;
    cycles(45);
    check("t6_vld_before_rst", {31'd0, key_vld}, 32'd1);
    check("t6_code_before_rst", {28'd0, key_code}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_vld", {31'd0, key_vld}, 32'd0);
    check("t6_rst_clm", {28'd0, clm}, 32'he);
    pressed = '0;
    cycles(3);
    rst_n = 1'b1;
    key_rdy = 1'b1;
    cycles(60);
    check("t6_no_key_after_release", {31'd0, key_vld}, 32'd0);

    // 6b: 30 random single presses, sequence must match
    for (int i = 0; i < 30; i++) begin
      k = int'($urandom_range(0, 15));
      exp_q.push_back(4'(k));
      pressed[k] = 1'b1;
      wait_drain("t6_rand_key", 45);
      cycles(10);
      pressed = '0;
      cycles(40);
    end
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
